// File: rtl/mm_pkg.sv
// mm_pkg: matrix-multiply dimensions, address widths and controller state encoding shared with input_mems
package mm_pkg;
    localparam int M           = 7;
    localparam int N           = 9;
    localparam int MAXK        = 8;
    localparam int MAC_LAT     = 1;
    localparam int K_BITS      = $clog2(MAXK + 1);
    localparam int A_ADDR_BITS = $clog2(M * MAXK);
    localparam int B_ADDR_BITS = $clog2(MAXK * N);
    localparam int M_BITS      = $clog2(M);
    localparam int N_BITS      = $clog2(N);
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, CLEAR} ctrl_state_t;
endpackage

// File: rtl/mm_delay_line.sv
// mm_delay_line: fixed-depth strobe shift register aligning control with memory and MAC latency
module mm_delay_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] pipe [DEPTH];
    // advance one stage per cycle; reset flushes every strobe in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i - 1];
        end
    end
    assign q = pipe[DEPTH - 1];
endmodule

// File: rtl/mm_compute_ctrl.sv
// mm_compute_ctrl: sequences A/B reads and MAC/result strobes for C = A * B with output backpressure
module mm_compute_ctrl
    import mm_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   matrices_loaded,
    input  logic [K_BITS-1:0]      K,
    output logic                   compute_finished,
    output logic [A_ADDR_BITS-1:0] A_read_addr,
    output logic [B_ADDR_BITS-1:0] B_read_addr,
    output logic                   mac_valid,
    output logic                   mac_init,
    output logic                   result_valid,
    output logic                   result_last,
    input  logic                   out_ready
);
    ctrl_state_t state, next_state;
    logic [K_BITS-1:0]      kq, k;
    logic [M_BITS-1:0]      m;
    logic [N_BITS-1:0]      n;
    logic [A_ADDR_BITS-1:0] a_base;
    logic [B_ADDR_BITS-1:0] b_addr;
    logic                   issue, eoe, last, row_end;
    logic [1:0]             mac_q, res_q;

    assign eoe     = issue && k == kq - 1'b1;
    assign row_end = n == N_BITS'(N - 1);
    assign last    = eoe && row_end && m == M_BITS'(M - 1);

    // state register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // next-state logic; a zero K skips straight to the finish pulse
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (matrices_loaded) next_state = (K == '0) ? DONE : ISSUE;
            ISSUE:   if (last) next_state = DRAIN;
            DRAIN:   if (result_valid && result_last) next_state = DONE;
            DONE:    next_state = CLEAR;
            CLEAR:   if (!matrices_loaded) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // issue decision and read addresses; a new element only starts when the output stage has a slot
    always_comb begin
        issue       = state == ISSUE && (k != '0 || out_ready);
        A_read_addr = a_base + A_ADDR_BITS'(k);
        B_read_addr = b_addr;
    end

    // element counters and multiplier-free address accumulators, held at zero outside ISSUE
    always_ff @(posedge clk) begin
        if (!reset || state != ISSUE) begin
            m      <= '0;
            n      <= '0;
            k      <= '0;
            a_base <= '0;
            b_addr <= '0;
        end else if (eoe) begin
            k      <= '0;
            n      <= row_end ? '0 : n + 1'b1;
            m      <= row_end ? m + 1'b1 : m;
            a_base <= row_end ? a_base + A_ADDR_BITS'(kq) : a_base;
            b_addr <= row_end ? '0 : B_ADDR_BITS'(n) + 1'b1;
        end else if (issue) begin
            k      <= k + 1'b1;
            b_addr <= b_addr + B_ADDR_BITS'(N);
        end
    end

    // shared dimension capture and registered finish pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            kq               <= '0;
            compute_finished <= 1'b0;
        end else begin
            kq               <= (state == IDLE && matrices_loaded) ? K : kq;
            compute_finished <= state == DONE;
        end
    end

    mm_delay_line #(.WIDTH(2), .DEPTH(1)) mac_dly (
        .clk   (clk),
        .reset (reset),
        .d     ({issue, issue && k == '0}),
        .q     (mac_q)
    );

    mm_delay_line #(.WIDTH(2), .DEPTH(1 + MAC_LAT)) res_dly (
        .clk   (clk),
        .reset (reset),
        .d     ({eoe, last}),
        .q     (res_q)
    );

    assign {mac_valid, mac_init}       = mac_q;
    assign {result_valid, result_last} = res_q;
endmodule

// File: tb/tb_mm_compute_ctrl.sv
// tb_mm_compute_ctrl: scoreboard bench for the matrix-multiply controller
module tb_mm_compute_ctrl;
    import mm_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   matrices_loaded = 1'b0;
    logic                   out_ready = 1'b1;
    logic [K_BITS-1:0]      K = '0;
    logic                   compute_finished, mac_valid, mac_init, result_valid, result_last;
    logic [A_ADDR_BITS-1:0] A_read_addr;
    logic [B_ADDR_BITS-1:0] B_read_addr;

    mm_compute_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .matrices_loaded  (matrices_loaded),
        .K                (K),
        .compute_finished (compute_finished),
        .A_read_addr      (A_read_addr),
        .B_read_addr      (B_read_addr),
        .mac_valid        (mac_valid),
        .mac_init         (mac_init),
        .result_valid     (result_valid),
        .result_last      (result_last),
        .out_ready        (out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int a;
        int b;
        bit init;
    } mac_t;

    mac_t mac_q[$];
    bit   res_q[$];
    int   fin_q[$];
    int   checks = 0, errors = 0;
    int   mac_seen = 0, res_seen = 0, fin_seen = 0;
    logic [A_ADDR_BITS-1:0] pa = '0;
    logic [B_ADDR_BITS-1:0] pb = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: addresses issued last cycle pair with this cycle's mac strobe
    always @(negedge clk) begin
        mac_t e;
        bit   r;
        int   f;
        if (mac_valid) begin
            mac_seen++;
            if (mac_q.size() == 0) chk("unexpected_mac", 1, 0);
            else begin
                e = mac_q.pop_front();
                chk("a_addr", int'(pa), e.a);
                chk("b_addr", int'(pb), e.b);
                chk("mac_init", int'(mac_init), int'(e.init));
            end
        end
        if (result_valid) begin
            res_seen++;
            if (res_q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                r = res_q.pop_front();
                chk("result_last", int'(result_last), int'(r));
            end
        end
        if (compute_finished) begin
            fin_seen++;
            if (fin_q.size() == 0) chk("unexpected_finish", 1, 0);
            else begin
                f = fin_q.pop_front();
                chk("finish_cycle", cyc, f);
            end
        end
        pa = A_read_addr;
        pb = B_read_addr;
    end

    // expected MAC reads for the first mac_el elements and results for the first res_el elements
    task automatic expect_run(input int kq, input int mac_el, input int res_el);
        mac_t e;
        for (int el = 0; el < M * N; el++) begin
            if (el < mac_el)
                for (int kk = 0; kk < kq; kk++) begin
                    e.a    = (el / N) * kq + kk;
                    e.b    = kk * N + (el % N);
                    e.init = kk == 0;
                    mac_q.push_back(e);
                end
            if (el < res_el) res_q.push_back(el == M * N - 1);
        end
    endtask

    task automatic start(input int kval, output int t);
        @(negedge clk);
        K = K_BITS'(kval);
        matrices_loaded = 1'b1;
        t = cyc;
    endtask

    task automatic wait_fin(input int budget);
        int f0;
        f0 = fin_seen;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fin_seen != f0) return;
        end
        chk("finish_timeout", 0, 1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_finished"}, int'(compute_finished), 0);
        chk({tag, "_a_addr"}, int'(A_read_addr), 0);
        chk({tag, "_b_addr"}, int'(B_read_addr), 0);
        chk({tag, "_mac_valid"}, int'(mac_valid), 0);
        chk({tag, "_mac_init"}, int'(mac_init), 0);
        chk({tag, "_result_valid"}, int'(result_valid), 0);
        chk({tag, "_result_last"}, int'(result_last), 0);
    endtask

    initial begin
        int t, m0, r0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b1;
        @(negedge clk);

        // K=8, 504 issue cycles + 2 pipeline + DONE + registered pulse
        r0 = res_seen;
        expect_run(8, 63, 63);
        start(8, t);
        fin_q.push_back(t + 508);
        wait_fin(700);
        chk("k8_result_count", res_seen - r0, 63);
        m0 = mac_seen;
        r0 = res_seen;
        repeat (3) @(negedge clk);
        chk("clear_hold_mac", mac_seen - m0, 0);
        chk("clear_hold_result", res_seen - r0, 0);
        chk("clear_hold_finish", fin_q.size(), 0);
        matrices_loaded = 1'b0;
        @(negedge clk);

        // K=1 after drop-and-raise: every term is init and last
        r0 = res_seen;
        expect_run(1, 63, 63);
        start(1, t);
        fin_q.push_back(t + 67);
        wait_fin(200);
        chk("k1_result_count", res_seen - r0, 63);
        matrices_loaded = 1'b0;
        @(negedge clk);

        // K=0: finish only, no strobes
        m0 = mac_seen;
        r0 = res_seen;
        start(0, t);
        fin_q.push_back(t + 2);
        wait_fin(20);
        chk("k0_mac_count", mac_seen - m0, 0);
        chk("k0_result_count", res_seen - r0, 0);
        matrices_loaded = 1'b0;
        @(negedge clk);

        // stall five cycles at element (0,3) start
        expect_run(8, 63, 63);
        start(8, t);
        fin_q.push_back(t + 513);
        while (cyc != t + 25) @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_a_addr", int'(A_read_addr), 0);
            chk("stall_b_addr", int'(B_read_addr), 3);
            chk("stall_mac_valid", int'(mac_valid), 0);
        end
        out_ready = 1'b1;
        wait_fin(700);
        matrices_loaded = 1'b0;
        @(negedge clk);

        // reset at element (2,4) start: reads up to (2,3) and results up to (2,2) survive
        expect_run(8, 22, 21);
        start(8, t);
        while (cyc != t + 177) @(negedge clk);
        reset = 1'b0;
        matrices_loaded = 1'b0;
        @(negedge clk);
        check_idle("midreset");
        chk("midreset_mac_q", mac_q.size(), 0);
        chk("midreset_res_q", res_q.size(), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // fresh run after abort restarts from element (0,0)
        r0 = res_seen;
        expect_run(1, 63, 63);
        start(1, t);
        fin_q.push_back(t + 67);
        wait_fin(200);
        chk("restart_result_count", res_seen - r0, 63);
        matrices_loaded = 1'b0;
        repeat (3) @(negedge clk);

        chk("end_mac_q", mac_q.size(), 0);
        chk("end_res_q", res_q.size(), 0);
        chk("end_fin_q", fin_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
